// File: rtl/bldc_seq_pkg.sv
// Shared state, step and commutation-table definitions for the BLDC sequencer.
package bldc_seq_pkg;

   typedef enum logic [2:0] {
      StIdle       = 3'd0,
      StOpenLoop   = 3'd1,
      StTransition = 3'd2,
      StClosedLoop = 3'd3,
      StFault      = 3'd4
   } state_e;

   typedef logic [2:0] step_t;

   localparam int unsigned NumSteps = 6;

   // Gate pattern {AH,AL,BH,BL,CH,CL}; step 0 sits in the lowest slot.
   localparam logic [NumSteps-1:0][5:0] CommTable = {
      6'b000110, 6'b010010, 6'b011000, 6'b001001, 6'b100001, 6'b100100
   };

   function automatic step_t step_next(input step_t s);
      return (s >= step_t'(NumSteps - 1)) ? step_t'(0) : s + step_t'(1);
   endfunction

   function automatic logic [5:0] comm_pattern(input step_t s);
      return (s < step_t'(NumSteps)) ? CommTable[s] : 6'b000000;
   endfunction

endpackage

// File: rtl/bldc_zc_detect.sv
// Back-EMF comparator synchroniser; flags any change of the synced vector as one edge.
module bldc_zc_detect (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [2:0] zc_i,
   output logic       edge_o
);

   logic [2:0] sync1_q, sync2_q, prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= zc_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign edge_o = (sync2_q != prev_q);

endmodule

// File: rtl/bldc_seq_ctrl.sv
// Sensorless BLDC commutation sequencer: open-loop ramp, transition, zero-crossing closed loop.
// Define BLDC_SEQ_ZC_TIMEOUT_EN to enable the closed-loop stall timeout and FAULT state.
module bldc_seq_ctrl
   import bldc_seq_pkg::*;
#(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned DUTY_W     = 16,
   parameter int unsigned SPEED_STEP = 2,
   parameter int unsigned DUTY_OL    = 200,
   parameter int unsigned ZC_TIMEOUT = 100000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic [DUTY_W-1:0] duty_i,
   input  logic [CNT_W-1:0]  ramp_time_i,
   input  logic [CNT_W-1:0]  trans_time_i,
   input  logic [CNT_W-1:0]  speed_start_i,
   input  logic [CNT_W-1:0]  speed_end_i,
   input  logic [2:0]        zero_crossing_i,
   output logic [5:0]        status_o,
   output logic [DUTY_W-1:0] duty_o,
   output logic [2:0]        state_o,
   output logic              fault_o
);

   state_e            state_q, state_d;
   step_t             step_q, step_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0]  ramp_cnt_q, ramp_cnt_d;
   logic [CNT_W-1:0]  trans_cnt_q, trans_cnt_d;
   logic [5:0]        status_q, status_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic              zc_edge;
   logic              per_wrap;
   logic [CNT_W:0]    period_floor;
   logic [CNT_W-1:0]  period_dec;

`ifdef BLDC_SEQ_ZC_TIMEOUT_EN
   logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
   logic              fault_q, fault_d;
`else
   logic              unused_zc_timeout;
   assign unused_zc_timeout = |CNT_W'(ZC_TIMEOUT);
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   bldc_zc_detect u_zc_detect (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .zc_i   (zero_crossing_i),
      .edge_o (zc_edge)
   );

   // One bit wider so period - SPEED_STEP cannot wrap below speed_end_i.
   assign period_floor = {1'b0, speed_end_i} + (CNT_W + 1)'(SPEED_STEP);
   assign period_dec   = ({1'b0, period_q} >= period_floor) ?
                         period_q - CNT_W'(SPEED_STEP) : speed_end_i;
   assign per_wrap     = (({1'b0, per_cnt_q} + (CNT_W + 1)'(1)) == {1'b0, period_q});

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      period_d    = period_q;
      per_cnt_d   = per_cnt_q;
      ramp_cnt_d  = ramp_cnt_q;
      trans_cnt_d = trans_cnt_q;
`ifdef BLDC_SEQ_ZC_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            step_d      = '0;
            per_cnt_d   = '0;
            ramp_cnt_d  = '0;
            trans_cnt_d = '0;
            if (start_i) begin
               state_d  = StOpenLoop;
               period_d = speed_start_i;
            end
         end
         StOpenLoop, StTransition: begin
            if (per_wrap) begin
               step_d    = step_next(step_q);
               per_cnt_d = '0;
               if (state_q == StOpenLoop) period_d = period_dec;
            end else begin
               per_cnt_d = sat_inc(per_cnt_q);
            end
            if (state_q == StOpenLoop) begin
               ramp_cnt_d = sat_inc(ramp_cnt_q);
               if ((period_q <= speed_end_i) || (ramp_cnt_d >= ramp_time_i)) begin
                  state_d     = StTransition;
                  trans_cnt_d = '0;
               end
            end else begin
               trans_cnt_d = sat_inc(trans_cnt_q);
               if (trans_cnt_d >= trans_time_i) begin
                  state_d = StClosedLoop;
`ifdef BLDC_SEQ_ZC_TIMEOUT_EN
                  to_cnt_d = '0;
`endif
               end
            end
         end
         StClosedLoop: begin
            if (zc_edge) step_d = step_next(step_q);
`ifdef BLDC_SEQ_ZC_TIMEOUT_EN
            to_cnt_d = zc_edge ? '0 : sat_inc(to_cnt_q);
            if (to_cnt_d >= CNT_W'(ZC_TIMEOUT)) state_d = StFault;
`endif
         end
         StFault: begin
            state_d = StFault;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // Stop overrides everything, including a simultaneous start or fault.
      if (stop_i) state_d = StIdle;
   end

   always_comb begin
      status_d = '0;
      duty_d   = '0;
      if (state_q == StOpenLoop || state_q == StTransition) begin
         status_d = comm_pattern(step_q);
         duty_d   = DUTY_W'(DUTY_OL);
      end else if (state_q == StClosedLoop) begin
         status_d = comm_pattern(step_q);
         duty_d   = duty_i;
      end
   end

`ifdef BLDC_SEQ_ZC_TIMEOUT_EN
   // Fault flag tracks the state register so it rises and clears with state_o.
   assign fault_d = (state_d == StFault);
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         step_q      <= '0;
         period_q    <= '0;
         per_cnt_q   <= '0;
         ramp_cnt_q  <= '0;
         trans_cnt_q <= '0;
         status_q    <= '0;
         duty_q      <= '0;
`ifdef BLDC_SEQ_ZC_TIMEOUT_EN
         to_cnt_q    <= '0;
         fault_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         period_q    <= period_d;
         per_cnt_q   <= per_cnt_d;
         ramp_cnt_q  <= ramp_cnt_d;
         trans_cnt_q <= trans_cnt_d;
         status_q    <= status_d;
         duty_q      <= duty_d;
`ifdef BLDC_SEQ_ZC_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
         fault_q     <= fault_d;
`endif
      end
   end

   assign status_o = status_q;
   assign duty_o   = duty_q;
   assign state_o  = state_q;
`ifdef BLDC_SEQ_ZC_TIMEOUT_EN
   assign fault_o  = fault_q;
`else
   assign fault_o  = 1'b0;
`endif

endmodule
